// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: round-robin grant between a fetch port and a data port
// onto a single memory command channel, with per-access timeout.
module mem_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              wnr0,
    input  logic              wnr1,
    output logic              ack0,
    output logic              ack1,
    output logic              err0,
    output logic              err1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] memAddress,
    output logic [DATA_W-1:0] memWdata,
    output logic              memWnR,
    output logic              memSelect,
    input  logic [DATA_W-1:0] memRdata,
    input  logic              memValid,
    output logic              busy
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              ptr_q, ptr_d;
    logic              gnt_q, gnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              wnr_q, wnr_d;
    logic              sel_q, sel_d;
    logic              busy_q, busy_d;
    logic              ack0_q, ack0_d, ack1_q, ack1_d;
    logic              err0_q, err0_d, err1_q, err1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

    logic              elig0_s, elig1_s, pick1_s;

    // A port is masked while its own completion pulse is still visible.
    assign elig0_s = req0 & ~ack0_q & ~err0_q;
    assign elig1_s = req1 & ~ack1_q & ~err1_q;

    // Next-state and registered-output computation.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        gnt_d    = gnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wnr_d    = wnr_q;
        sel_d    = sel_q;
        busy_d   = busy_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        err0_d   = 1'b0;
        err1_d   = 1'b0;
        pick1_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (elig0_s || elig1_s) begin
                    // ptr_q == 1 gives port 1 priority on a tie
                    pick1_s = elig1_s && (!elig0_s || ptr_q);
                    addr_d  = pick1_s ? addr1  : addr0;
                    wdata_d = pick1_s ? wdata1 : wdata0;
                    wnr_d   = pick1_s ? wnr1   : wnr0;
                    sel_d   = 1'b1;
                    busy_d  = 1'b1;
                    cnt_d   = 8'd0;
                    gnt_d   = pick1_s;
                    ptr_d   = ~pick1_s;
                    state_d = BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (memValid) begin
                    sel_d   = 1'b0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                    if (gnt_q) begin
                        ack1_d = 1'b1;
                        if (!wnr_q) begin
                            rdata1_d = memRdata;
                        end else begin
                            rdata1_d = rdata1_q;
                        end
                    end else begin
                        ack0_d = 1'b1;
                        if (!wnr_q) begin
                            rdata0_d = memRdata;
                        end else begin
                            rdata0_d = rdata0_q;
                        end
                    end
                end else if (cnt_q == CNT_LAST) begin
                    sel_d   = 1'b0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                    if (gnt_q) begin
                        err1_d = 1'b1;
                    end else begin
                        err0_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                sel_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 8'd0;
            ptr_q    <= 1'b0;
            gnt_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wnr_q    <= 1'b0;
            sel_q    <= 1'b0;
            busy_q   <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            err0_q   <= 1'b0;
            err1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wnr_q    <= wnr_d;
            sel_q    <= sel_d;
            busy_q   <= busy_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            err0_q   <= err0_d;
            err1_q   <= err1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign ack0       = ack0_q;
    assign ack1       = ack1_q;
    assign err0       = err0_q;
    assign err1       = err1_q;
    assign rdata0     = rdata0_q;
    assign rdata1     = rdata1_q;
    assign memAddress = addr_q;
    assign memWdata   = wdata_q;
    assign memWnR     = wnr_q;
    assign memSelect  = sel_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: one-cycle memory model, per-port response
// queues and an expected grant-order queue.
module tb_mem_arbiter;

    logic        clk, rst;
    logic        req0, req1, wnr0, wnr1;
    logic [15:0] addr0, addr1, wdata0, wdata1;
    logic        ack0, ack1, err0, err1;
    logic [15:0] rdata0, rdata1;
    logic [15:0] memAddress, memWdata, mem_rdata;
    logic        memWnR, memSelect, memValid, busy;
    logic        mv_q, force_v, stall, sel_d1;

    logic [15:0] tb_mem  [256];
    logic [15:0] ref_mem [256];

    typedef struct packed {
        logic        err;
        logic        wr;
        logic [15:0] data;
    } exp_t;

    exp_t exp0[$];
    exp_t exp1[$];
    logic gnt_exp[$];

    int n_total = 0;
    int n_bad   = 0;

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1),
        .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .wnr0(wnr0), .wnr1(wnr1),
        .ack0(ack0), .ack1(ack1),
        .err0(err0), .err1(err1),
        .rdata0(rdata0), .rdata1(rdata1),
        .memAddress(memAddress), .memWdata(memWdata),
        .memWnR(memWnR), .memSelect(memSelect),
        .memRdata(mem_rdata), .memValid(memValid),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // One-cycle memory: answers the cycle after it sees memSelect, unless stalled.
    assign memValid = mv_q | force_v;
    always @(posedge clk) begin
        sel_d1 <= memSelect;
        if (rst) begin
            mv_q          <= 1'b0;
            tb_mem[8'h10] <= 16'hBEEF;
            tb_mem[8'h20] <= 16'hA020;
            tb_mem[8'h21] <= 16'hA021;
            tb_mem[8'h31] <= 16'hB031;
            tb_mem[8'h32] <= 16'hB032;
        end else if (memSelect && !mv_q && !stall) begin
            mv_q <= 1'b1;
            if (memWnR) tb_mem[memAddress[7:0]] <= memWdata;
            else        mem_rdata <= tb_mem[memAddress[7:0]];
        end else begin
            mv_q <= 1'b0;
        end
    end

    // Grant-order and pulse-exclusivity monitor.
    always @(negedge clk) begin
        logic g;
        if (!rst) begin
            check("excl", 32'({ack0 & ack1, ack0 & err0, ack1 & err1, ack0 & err1, ack1 & err0}), 32'd0);
            if (memSelect && !sel_d1 && gnt_exp.size() > 0) begin
                g = gnt_exp.pop_front();
                check("grant", 32'(memAddress[4]), 32'(g));
            end
        end
    end

    task automatic do_access(input int p, input logic [15:0] a, input logic [15:0] d,
                             input logic w, input bit exp_err, input bit chk_cmd,
                             output int lat);
        exp_t e, o;
        logic got;
        @(negedge clk);
        if (p == 0) begin req0 = 1'b1; addr0 = a; wdata0 = d; wnr0 = w; end
        else        begin req1 = 1'b1; addr1 = a; wdata1 = d; wnr1 = w; end
        e.err  = exp_err;
        e.wr   = w;
        e.data = ref_mem[a[7:0]];
        if (!exp_err && w) ref_mem[a[7:0]] = d;
        if (p == 0) exp0.push_back(e); else exp1.push_back(e);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (chk_cmd && lat == 1) begin
                check("cmd_sel",  32'(memSelect), 32'd1);
                check("cmd_addr", 32'(memAddress), 32'(a));
                check("cmd_wnr",  32'(memWnR), 32'(w));
            end
            got = (p == 0) ? (ack0 | err0) : (ack1 | err1);
        end
        check("resp_seen", 32'(got), 32'd1);
        if (got) begin
            o = (p == 0) ? exp0.pop_front() : exp1.pop_front();
            check("resp_err", 32'((p == 0) ? err0 : err1), 32'(o.err));
            check("resp_ack", 32'((p == 0) ? ack0 : ack1), 32'(!o.err));
            if (!o.err && !o.wr)
                check("rdata", 32'((p == 0) ? rdata0 : rdata1), 32'(o.data));
        end
        @(posedge clk); #1;
        check("pulse_end", 32'((p == 0) ? {ack0, err0} : {ack1, err1}), 32'd0);
        if (p == 0) req0 = 1'b0; else req1 = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); @(negedge clk); rst = 1'b0;
    endtask

    initial begin
        int lat, la, lb;
        rst = 1'b1; force_v = 1'b0; stall = 1'b0;
        req0 = 1'b0; req1 = 1'b0; wnr0 = 1'b0; wnr1 = 1'b0;
        addr0 = 16'h0; addr1 = 16'h0; wdata0 = 16'h0; wdata1 = 16'h0;
        ref_mem[8'h10] = 16'hBEEF;
        ref_mem[8'h20] = 16'hA020;
        ref_mem[8'h21] = 16'hA021;
        ref_mem[8'h31] = 16'hB031;
        ref_mem[8'h32] = 16'hB032;

        repeat (2) @(posedge clk);
        #1;
        check("rst_ctl",   32'({ack0, ack1, err0, err1, busy, memSelect, memWnR}), 32'd0);
        check("rst_addr",  32'(memAddress), 32'd0);
        check("rst_wdata", 32'(memWdata), 32'd0);
        check("rst_rdata", 32'({rdata0, rdata1}), 32'd0);
        @(negedge clk); rst = 1'b0;

        // Single read on port 0 with nominal latency
        do_access(0, 16'h0010, 16'h0000, 1'b0, 1'b0, 1'b1, lat);
        check("lat_read", 32'(lat), 32'd3);

        // Write then read back on port 1
        do_access(1, 16'h0005, 16'h1234, 1'b1, 1'b0, 1'b1, lat);
        do_access(1, 16'h0005, 16'h0000, 1'b0, 1'b0, 1'b1, lat);

        // Contention from reset: strict alternation
        pulse_reset();
        gnt_exp.push_back(1'b0); gnt_exp.push_back(1'b1);
        gnt_exp.push_back(1'b0); gnt_exp.push_back(1'b1);
        fork
            begin
                do_access(0, 16'h0020, 16'h0, 1'b0, 1'b0, 1'b0, la);
                do_access(0, 16'h0021, 16'h0, 1'b0, 1'b0, 1'b0, la);
            end
            begin
                do_access(1, 16'h0031, 16'h0, 1'b0, 1'b0, 1'b0, lb);
                do_access(1, 16'h0032, 16'h0, 1'b0, 1'b0, 1'b0, lb);
            end
        join
        check("gnt_left", 32'(gnt_exp.size()), 32'd0);

        // Timeout with a silent memory, then a late response in IDLE
        stall = 1'b1;
        do_access(1, 16'h0040, 16'h0, 1'b0, 1'b1, 1'b1, lat);
        check("lat_to", 32'(lat), 32'd9);
        check("to_idle", 32'({memSelect, busy}), 32'd0);
        @(negedge clk); force_v = 1'b1;
        @(posedge clk); #1; force_v = 1'b0;
        check("late_valid", 32'({ack0, ack1, err0, err1, memSelect}), 32'd0);
        @(posedge clk); #1;
        check("late_valid2", 32'({ack0, ack1, err0, err1, memSelect}), 32'd0);
        stall = 1'b0;

        // Reset one cycle after a port-0 grant aborts the access and clears the pointer
        @(negedge clk); req0 = 1'b1; addr0 = 16'h0010; wnr0 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_sel", 32'(memSelect), 32'd1);
        rst = 1'b1; #1;
        check("rst_async", 32'({memSelect, busy}), 32'd0);
        req0 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            check("post_rst", 32'({ack0, ack1, err0, err1, memSelect}), 32'd0);
        end
        gnt_exp.push_back(1'b0); gnt_exp.push_back(1'b1);
        fork
            do_access(1, 16'h0031, 16'h0, 1'b0, 1'b0, 1'b0, lb);
            do_access(0, 16'h0020, 16'h0, 1'b0, 1'b0, 1'b0, la);
        join
        check("gnt_left2", 32'(gnt_exp.size()), 32'd0);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, meaning address width.
REQ-002 The block SHALL have parameter DATA_W, default 16, meaning data width.
REQ-003 The block SHALL have parameter TIMEOUT, default 8, meaning maximum BUSY cycles to wait for memValid (legal range 2..255).
REQ-004 The block SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 The block SHALL have ports req0/req1  input  1  access request from port 0 (fetch) and port 1 (data).
REQ-007 The block SHALL have ports addr0/addr1  input  ADDR_W  word address per port.
REQ-008 The block SHALL have ports wdata0/wdata1  input  DATA_W  write data per port.
REQ-009 The block SHALL have ports wnr0/wnr1  input  1  1 = write, 0 = read, per port.
REQ-010 The block SHALL have ports ack0/ack1  output  1  one-cycle completion pulse per port.
REQ-011 The block SHALL have ports err0/err1  output  1  one-cycle timeout pulse per port.
REQ-012 The block SHALL have ports rdata0/rdata1  output  DATA_W  read data per port, valid while ackN=1.
REQ-013 The block SHALL have ports memAddress  output  ADDR_W, memWdata  output  DATA_W, memWnR  output  1, memSelect  output  1  memory command.
REQ-014 The block SHALL have ports memRdata  input  DATA_W, memValid  input  1  memory response.
REQ-015 The block SHALL have port busy  output  1  high while in BUSY state.

Function
REQ-016 All outputs SHALL be registered; states SHALL be IDLE and BUSY.
REQ-017 In IDLE, a port SHALL be eligible when reqN=1 and ackN=0 and errN=0 in that cycle (masks a request still high during its own completion pulse).
REQ-018 If exactly one port is eligible, IDLE SHALL grant it; if both, the port holding the priority pointer SHALL win.
REQ-019 On grant: latch addrN/wdataN/wnrN onto memAddress/memWdata/memWnR, set memSelect=1, busy=1, clear timeout counter, record granted port, move pointer to the other port, go BUSY.
REQ-020 In BUSY, memAddress/memWdata/memWnR/memSelect SHALL remain stable until exit.
REQ-021 In BUSY with memValid=1: memSelect<=0, busy<=0, ackN<=1 for granted port, rdataN<=memRdata if read (rdataN unchanged on write), go IDLE.
REQ-022 In BUSY with memValid=0: counter increments; when counter reaches TIMEOUT-1, memSelect<=0, busy<=0, errN<=1 (ackN stays 0), go IDLE.
REQ-023 Latency SHALL be: req sampled at edge E0, memSelect high after E0, memValid expected after E1, ackN high after E2 for a one-cycle memory; next grant earliest at E3.
REQ-024 ackN/errN SHALL be high exactly one cycle; ack and err SHALL never both be high; ack0 and ack1 SHALL never both be high.
REQ-025 memValid in IDLE SHALL be ignored (late response after timeout produces no ack).
REQ-026 Requesters SHALL hold req and command stable until they sample ackN or errN, and deassert req on that edge; changes to addrN/wdataN/wnrN during BUSY SHALL not affect the issued access.
REQ-027 A request dropped before grant SHALL be discarded without memory access.
REQ-028 With both ports requesting continuously, grants SHALL alternate 0,1,0,1.

Reset
REQ-029 rst=1 SHALL immediately, independent of clk, force IDLE, memSelect=0, memWnR=0, memAddress=0, memWdata=0, ack0/1=0, err0/1=0, rdata0/1=0, busy=0, counter=0, pointer=port 0.
REQ-030 Reset asserted in BUSY SHALL abort the access with no ack or err; first grant after release follows REQ-018 with pointer at port 0.

Verification
REQ-031 Single read: mem[0x0010]=0xBEEF, req0=1 addr0=0x0010 wnr0=0 -> memSelect high 1 cycle-window, ack0 pulse two edges after grant with rdata0=0xBEEF, ack1=0.
REQ-032 Write then read: port1 writes 0x1234 to 0x0005, then reads 0x0005 -> memWnR=1 on first access, second ack1 rdata1=0x1234.
REQ-033 Contention: req0=req1=1 from reset, held 4 accesses -> grant order 0,1,0,1; no duplicate grant per ack.
REQ-034 Timeout: memory stubbed memValid=0, req1=1 -> err1 pulse after TIMEOUT=8 BUSY cycles, memSelect low, ack1=0; forced late memValid in IDLE -> no ack.
REQ-035 Reset mid-access: assert rst one cycle after grant -> memSelect=0 and busy=0 asynchronously, no ack/err after release; req1 and req0 both pending -> port 0 granted first.
